// File: rtl/panda_id_stage.sv
// Panda core instruction decode stage: RV32I decode, 32x32 register file with
// write-back bypass, immediate generation, load-use detection and ID/EX register.
package panda_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    XOR  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    OR   = 4'd8,
    AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_inc;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    alu_op_e     alu_op;
    logic [1:0]  alu_src_a;
    logic        alu_src_b_imm;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        branch;
    logic [2:0]  branch_op;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } id_ex_t;

endpackage

module panda_id_stage
  import panda_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        flush_i,
  input  if_id_t      if_id_i,
  output id_ex_t      id_ex_o,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  output logic        load_use_hazard_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rf [31:1];
  logic        illegal, rs1_used, rs2_used;
  id_ex_t      dec;

  assign instr    = if_id_i.instr;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_from_f3 = alt ? SUB : ADD;
      3'd1:    alu_from_f3 = SLL;
      3'd2:    alu_from_f3 = SLT;
      3'd3:    alu_from_f3 = SLTU;
      3'd4:    alu_from_f3 = XOR;
      3'd5:    alu_from_f3 = alt ? SRA : SRL;
      3'd6:    alu_from_f3 = OR;
      default: alu_from_f3 = AND;
    endcase
  endfunction

  // x0 has no storage; it is hardwired to zero on the read side
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < 32; i++) rf[i] <= '0;
    end else if (wb_we_i && wb_waddr_i != 5'd0) begin
      rf[wb_waddr_i] <= wb_wdata_i;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != 5'd0)
      rs1_data = (wb_we_i && wb_waddr_i == rs1_addr) ? wb_wdata_i : rf[rs1_addr];
    if (rs2_addr != 5'd0)
      rs2_data = (wb_we_i && wb_waddr_i == rs2_addr) ? wb_wdata_i : rf[rs2_addr];
  end

  always_comb begin
    dec          = '0;
    illegal      = 1'b0;
    rs1_used     = 1'b0;
    rs2_used     = 1'b0;
    dec.pc       = if_id_i.pc;
    dec.pc_inc   = if_id_i.pc_inc;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.rs1_addr = rs1_addr;
    dec.rs2_addr = rs2_addr;
    dec.rd_addr  = instr[11:7];
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          rs1_used      = 1'b1;
          rs2_used      = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_op    = alu_from_f3(funct3, funct7[5]);
          if (funct7 == 7'h20) illegal = (funct3 != 3'd0) && (funct3 != 3'd5);
          else                 illegal = (funct7 != 7'h00);
        end
        OPC_OPIMM: begin
          rs1_used          = 1'b1;
          dec.reg_write     = 1'b1;
          dec.alu_src_b_imm = 1'b1;
          dec.imm           = imm_i;
          dec.alu_op        = alu_from_f3(funct3, (funct3 == 3'd5) && funct7[5]);
          // funct7 only qualifies the shift-immediate encodings
          if (funct3 == 3'd1)      illegal = (funct7 != 7'h00);
          else if (funct3 == 3'd5) illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
        end
        OPC_LUI: begin
          dec.reg_write     = 1'b1;
          dec.alu_src_a     = 2'd2;
          dec.alu_src_b_imm = 1'b1;
          dec.imm           = imm_u;
        end
        OPC_AUIPC: begin
          dec.reg_write     = 1'b1;
          dec.alu_src_a     = 2'd1;
          dec.alu_src_b_imm = 1'b1;
          dec.imm           = imm_u;
        end
        OPC_LOAD: begin
          rs1_used          = 1'b1;
          dec.mem_read      = 1'b1;
          dec.reg_write     = 1'b1;
          dec.wb_sel        = 2'd1;
          dec.alu_src_b_imm = 1'b1;
          dec.imm           = imm_i;
          dec.mem_size      = funct3[1:0];
          dec.mem_unsigned  = funct3[2];
          illegal           = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        OPC_STORE: begin
          rs1_used          = 1'b1;
          rs2_used          = 1'b1;
          dec.mem_write     = 1'b1;
          dec.alu_src_b_imm = 1'b1;
          dec.imm           = imm_s;
          dec.mem_size      = funct3[1:0];
          illegal           = (funct3 > 3'd2);
        end
        OPC_BRANCH: begin
          rs1_used      = 1'b1;
          rs2_used      = 1'b1;
          dec.branch    = 1'b1;
          dec.branch_op = funct3;
          dec.imm       = imm_b;
          illegal       = (funct3 == 3'd2) || (funct3 == 3'd3);
        end
        OPC_JAL: begin
          dec.jal           = 1'b1;
          dec.reg_write     = 1'b1;
          dec.wb_sel        = 2'd2;
          dec.alu_src_a     = 2'd1;
          dec.alu_src_b_imm = 1'b1;
          dec.imm           = imm_j;
        end
        OPC_JALR: begin
          rs1_used          = 1'b1;
          dec.jalr          = 1'b1;
          dec.reg_write     = 1'b1;
          dec.wb_sel        = 2'd2;
          dec.alu_src_b_imm = 1'b1;
          dec.imm           = imm_i;
          illegal           = (funct3 != 3'd0);
        end
        OPC_FENCE: ;
        default: illegal = 1'b1;
      endcase
    end
    // an illegal instruction must not trigger any side effect downstream
    if (illegal) begin
      rs1_used          = 1'b0;
      rs2_used          = 1'b0;
      dec.alu_op        = ADD;
      dec.alu_src_a     = 2'd0;
      dec.alu_src_b_imm = 1'b0;
      dec.mem_read      = 1'b0;
      dec.mem_write     = 1'b0;
      dec.mem_size      = 2'd0;
      dec.mem_unsigned  = 1'b0;
      dec.reg_write     = 1'b0;
      dec.wb_sel        = 2'd0;
      dec.branch        = 1'b0;
      dec.branch_op     = 3'd0;
      dec.jal           = 1'b0;
      dec.jalr          = 1'b0;
      dec.illegal       = 1'b1;
    end
    if (dec.rd_addr == 5'd0) dec.reg_write = 1'b0;
  end

  assign load_use_hazard_o = id_ex_o.mem_read && (id_ex_o.rd_addr != 5'd0) &&
                             ((rs1_used && id_ex_o.rd_addr == rs1_addr) ||
                              (rs2_used && id_ex_o.rd_addr == rs2_addr));

  // A bubble is all-zero, which also encodes alu_op = ADD
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                             id_ex_o <= '0;
    else if (stall_i)                        id_ex_o <= id_ex_o;
    else if (flush_i || load_use_hazard_o)   id_ex_o <= '0;
    else                                     id_ex_o <= dec;
  end

endmodule

// File: doc/panda_id_stage.md
# panda_id_stage

Instruction decode stage of the Panda core: consumes the IF/ID pipeline register, decodes the RV32I instruction, reads the 32×32 integer register file, generates immediates and control, and registers everything into the ID/EX pipeline register. It also owns the register file write port driven from write-back and detects load-use hazards against the instruction currently in EX.

## Interface
- No parameters; XLEN fixed at 32.
- `clk_i`  in  1  core clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `stall_i`  in  1  hold ID/EX register
- `flush_i`  in  1  load bubble into ID/EX
- `if_id_i`  in  `panda_pkg::if_id_t`  instr, pc, pc_inc from fetch
- `id_ex_o`  out  `panda_pkg::id_ex_t`  registered decode result
- `wb_we_i`  in  1  register file write enable
- `wb_waddr_i`  in  5  write address
- `wb_wdata_i`  in  32  write data
- `load_use_hazard_o`  out  1  combinational; controller stalls IF with it
- `id_ex_t` fields: pc, pc_inc, rs1_data, rs2_data, imm (32 each); rs1_addr, rs2_addr, rd_addr (5); alu_op (`panda_pkg::alu_op_e`: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND); alu_src_a (2b: 0=rs1, 1=pc, 2=zero); alu_src_b_imm; mem_read; mem_write; mem_size (2b, funct3[1:0]); mem_unsigned; reg_write; wb_sel (2b: 0=alu, 1=mem, 2=pc_inc); branch; branch_op (funct3); jal; jalr; illegal.

## Operation
- Register file: x1..x31 flops, reset to 0; x0 reads 0, writes to x0 ignored. Write at posedge when `wb_we_i`. Read bypass: if `wb_we_i` and `wb_waddr_i` equals a nonzero read address, read data is `wb_wdata_i`.
- Immediates per RV32I I/S/B/U/J formats, sign-extended from instr[31]; R-type imm = 0.
- Decode:
  - OP/OP-IMM → ALU ops from funct3/funct7[5]; SUB only for OP.
  - LUI → zero+imm.
  - AUIPC → pc+imm.
  - LOAD → mem_read, wb_sel=mem, ADD rs1+imm.
  - STORE → mem_write.
  - BRANCH → branch, branch_op.
  - JAL/JALR → jal/jalr, wb_sel=pc_inc.
  - FENCE → NOP.
- reg_write forced 0 when rd_addr = 0.
- Illegal, which sets illegal=1 with all control bits zero:
  - instr[1:0] ≠ 2'b11;
  - unknown opcode;
  - SYSTEM opcode;
  - funct7 not 0x00/0x20 where used, or 0x20 with an invalid funct3;
  - load funct3 3/6/7;
  - store funct3 > 2;
  - branch funct3 2/3;
  - JALR funct3 ≠ 0.
- Load-use hazard: `id_ex_o.mem_read` and `id_ex_o.rd_addr` ≠ 0 and equal to rs1 (if used) or rs2 (if used by OP/STORE/BRANCH).
- Bubble: every field 0 except alu_op=ADD.
- ID/EX update priority:
  1. reset → all fields 0;
  2. `stall_i` → hold;
  3. `flush_i` → bubble;
  4. `load_use_hazard_o` → bubble;
  5. otherwise decoded values.

## Timing
- Decode, register read and hazard detection are combinational; `id_ex_o` updates one clock after `if_id_i` is presented.
- All `id_ex_o` fields reset to 0. `load_use_hazard_o` is 0 after reset.
- Write-back in cycle N is visible to the instruction decoded in cycle N through the bypass, and from the array from N+1.
- Stall together with flush: hold wins, no bubble.
- Load-use: exactly one bubble. After the bubble the load leaves EX, the hazard drops, and the held instruction decodes with the bypassed or array value.
- Reset mid-operation clears the register file and ID/EX asynchronously.

## Test plan
- Reset, then `if_id_i.instr`=0x00500093 (addi x1,x0,5) → next cycle rd_addr=1, imm=5, alu_op=ADD, alu_src_b_imm=1, reg_write=1, illegal=0.
- `wb_we_i`=1, `wb_waddr_i`=3, `wb_wdata_i`=0xDEADBEEF, same cycle decode add x4,x3,x0 (0x00018233) → rs1_data=0xDEADBEEF. Then write x0=0x1234 and read x0 → 0.
- Load-use check:
  - Decode lw x5,0(x1), then add x6,x5,x5 → `load_use_hazard_o`=1 for one cycle and a bubble enters ID/EX (reg_write=0, mem_read=0).
  - With the add held, next cycle the add is decoded normally.
  - Same scenario with rd=x0 → no hazard.
- Immediates:
  - beq x0,x0,−4 (0xFE000EE3) → imm=0xFFFFFFFC, branch=1, branch_op=0.
  - jal x1,2048 (0x001000EF) → imm=0x800, wb_sel=2.
  - lui x2,0x12345 → imm=0x12345000, alu_src_a=2.
- Illegal decode:
  - 0x00000000, ecall 0x00000073 and OP with funct7=0x01 → illegal=1, reg_write=0.
  - fence 0x0000000F → illegal=0, all control 0.
- Control priority:
  - `flush_i`=1 → bubble.
  - `stall_i`=`flush_i`=1 → `id_ex_o` unchanged.
  - Assert `rst_ni`=0 mid-stream → all outputs and x1..x31 read 0.
